// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache memory-side adapter.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BURST,
        READ_BURST,
        DONE
    } adapter_state_t;

    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
    localparam int OFFSET_BITS    = $clog2(LINE_W / 8);

endpackage

// File: rtl/cache_line_mem_adapter.sv
// Turns line-level fetch/writeback requests from the cache controller into
// a sequence of single-word transfers on the main-memory bus.
module cache_line_mem_adapter #(
    parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
    parameter int WORD_W         = cache_pkg::WORD_W,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [ADDR_W-1:0]                line_addr,
    input  logic [WORDS_PER_LINE*WORD_W-1:0] wb_line_data,
    output logic                             ca_resp,
    output logic [WORDS_PER_LINE*WORD_W-1:0] rd_line_data,
    output logic                             bus_error,
    output logic                             mm_req,
    output logic                             mm_we,
    output logic [ADDR_W-1:0]                mm_addr,
    output logic [WORD_W-1:0]                mm_wdata,
    input  logic [WORD_W-1:0]                mm_rdata,
    input  logic                             mm_ack
);
    import cache_pkg::*;

    localparam int LINE_BITS  = WORDS_PER_LINE * WORD_W;
    localparam int LINE_OFS   = $clog2(LINE_BITS / 8);
    localparam int IDX_W      = $clog2(WORDS_PER_LINE);
    localparam int TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int WORD_BYTES = WORD_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);

    adapter_state_t         state, state_next;
    logic [IDX_W-1:0]       idx;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [LINE_BITS-1:0]   wb_shift;
    logic [LINE_BITS-1:0]   rd_shadow;
    logic                   accept_wr, accept_rd, word_done, last_word, timed_out;
    logic                   unused_bits;

    // The bottom shadow word is always shifted out before the line is
    // published, and the line-offset address bits are deliberately dropped.
    assign unused_bits = ^{line_addr[LINE_OFS-1:0], rd_shadow[WORD_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        word_done  = mm_req && mm_ack;
        last_word  = word_done && (idx == LAST_IDX);
        timed_out  = TMO_EN && mm_req && !mm_ack && (tmo_cnt == TMO_LAST);
        case (state)
            IDLE: begin
                if (mem_write) begin
                    accept_wr  = 1'b1;
                    state_next = WRITE_BURST;
                end else if (mem_read) begin
                    accept_rd  = 1'b1;
                    state_next = READ_BURST;
                end
            end
            WRITE_BURST, READ_BURST: begin
                if (last_word || timed_out) state_next = DONE;
            end
            DONE: begin
                if (!mem_read && !mem_write) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read words shift in from the top so word 0 lands in the lowest slot
    // once the whole line has arrived; write words shift out from the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            ca_resp      <= 1'b0;
            mm_req       <= 1'b0;
            mm_we        <= 1'b0;
            bus_error    <= 1'b0;
            mm_addr      <= '0;
            mm_wdata     <= '0;
            idx          <= '0;
            tmo_cnt      <= '0;
            wb_shift     <= '0;
            rd_shadow    <= '0;
            rd_line_data <= '0;
        end else begin
            bus_error <= 1'b0;
            if (accept_wr || accept_rd) begin
                ca_resp  <= 1'b1;
                mm_req   <= 1'b1;
                mm_we    <= accept_wr;
                mm_addr  <= {line_addr[ADDR_W-1:LINE_OFS], LINE_OFS'(0)};
                mm_wdata <= accept_wr ? wb_line_data[WORD_W-1:0] : '0;
                wb_shift <= wb_line_data;
                idx      <= '0;
                tmo_cnt  <= '0;
            end else if (word_done) begin
                tmo_cnt   <= '0;
                rd_shadow <= {mm_rdata, rd_shadow[LINE_BITS-1:WORD_W]};
                if (last_word) begin
                    ca_resp <= 1'b0;
                    mm_req  <= 1'b0;
                    mm_we   <= 1'b0;
                    idx     <= '0;
                    if (state == READ_BURST)
                        rd_line_data <= {mm_rdata, rd_shadow[LINE_BITS-1:WORD_W]};
                end else begin
                    idx      <= idx + IDX_W'(1);
                    mm_addr  <= mm_addr + ADDR_W'(WORD_BYTES);
                    wb_shift <= wb_shift >> WORD_W;
                    mm_wdata <= wb_shift[2*WORD_W-1:WORD_W];
                end
            end else if (timed_out) begin
                bus_error <= 1'b1;
                ca_resp   <= 1'b0;
                mm_req    <= 1'b0;
                mm_we     <= 1'b0;
                idx       <= '0;
                tmo_cnt   <= '0;
            end else if (mm_req) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule
